// File: rtl/parallel_input.sv
// Memory-mapped input port: synchronised pins, sticky edge flags and a maskable level irq.
// Optional pin debouncer is compiled in with PARALLEL_INPUT_DEBOUNCE_EN.
module parallel_input #(
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0100,
  parameter int          WIDTH        = 32,
  parameter int          SYNC_STAGES  = 2,
  parameter int          DEBOUNCE_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  input  logic             ren,
  input  logic             wen,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic             active,
  input  logic [WIDTH-1:0] io,
  output logic             irq
);

  if (SYNC_STAGES < 2 || WIDTH < 1 || WIDTH > 32 || BASE_ADDR[3:0] != 4'h0 ||
      DEBOUNCE_DIV < 1) begin : g_param_check
    $error("parallel_input: illegal parameter set");
  end

  // Edge detection stays off until the pin path behind prev has settled from its
  // reset value, so pins that are high at reset never raise a spurious flag.
`ifdef PARALLEL_INPUT_DEBOUNCE_EN
  localparam int PRIME_CYCLES = SYNC_STAGES + 2 * DEBOUNCE_DIV + 1;
`else
  localparam int PRIME_CYCLES = SYNC_STAGES;
`endif
  localparam int PW = $clog2(PRIME_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rise_ev;
  logic [WIDTH-1:0] fall_ev;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [WIDTH-1:0] lane_en;
  logic [WIDTH-1:0] wdata_w;
  logic [31:0]      lane32;
  logic [31:0]      rd_val;
  logic [PW-1:0]    prime_cnt;
  logic             primed;
  logic             hit;
  logic             wr;
  logic [1:0]       off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef PARALLEL_INPUT_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [CW-1:0]    div_cnt;
  logic             tick;
  logic [WIDTH-1:0] samp_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] agree;

  assign tick  = (div_cnt == '0);
  assign agree = ~(samp_q ^ sync_val);

  // A bit only moves when the previous tick sample and the current one agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      samp_q   <= '0;
      stable_q <= '0;
    end else begin
      div_cnt <= tick ? CW'(DEBOUNCE_DIV - 1) : div_cnt - 1'b1;
      if (tick) begin
        samp_q   <= sync_val;
        stable_q <= (stable_q & ~agree) | (sync_val & agree);
      end
    end
  end

  assign pin_val = stable_q;
`else
  assign pin_val = sync_val;
`endif

  assign rise_ev = primed ? (pin_val & ~prev_q) : '0;
  assign fall_ev = primed ? (~pin_val & prev_q) : '0;

  assign active = (addr >= BASE_ADDR) && ({1'b0, addr} < ({1'b0, BASE_ADDR} + 33'd16));
  assign hit    = (ren | wen) & active;
  assign wr     = wen & active;
  assign off    = addr[3:2];

  always_comb begin
    lane32 = '0;
    for (int i = 0; i < 4; i++) lane32[8*i +: 8] = {8{wmask[i]}};
  end

  assign lane_en  = lane32[WIDTH-1:0];
  assign wdata_w  = wdata[WIDTH-1:0];
  assign rise_clr = (wr && off == 2'd1) ? (wdata_w & lane_en) : '0;
  assign fall_clr = (wr && off == 2'd2) ? (wdata_w & lane_en) : '0;

  always_comb begin
    rd_val = '0;
    case (off)
      2'd0: rd_val[WIDTH-1:0] = pin_val;
      2'd1: rd_val[WIDTH-1:0] = rise_q;
      2'd2: rd_val[WIDTH-1:0] = fall_q;
      default: rd_val[WIDTH-1:0] = mask_q;
    endcase
  end

  // Set wins over a same-cycle clear; read data is the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      primed    <= 1'b0;
      prime_cnt <= PW'(PRIME_CYCLES);
      rise_q    <= '0;
      fall_q    <= '0;
      mask_q    <= '0;
      irq       <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
    end else begin
      prev_q <= pin_val;
      if (!primed) begin
        if (prime_cnt == '0) primed <= 1'b1;
        else prime_cnt <= prime_cnt - 1'b1;
      end
      rise_q <= (rise_q & ~rise_clr) | rise_ev;
      fall_q <= (fall_q & ~fall_clr) | fall_ev;
      if (wr && off == 2'd3) mask_q <= (mask_q & ~lane_en) | (wdata_w & lane_en);
      irq   <= |((rise_q | fall_q) & mask_q);
      ready <= hit;
      rdata <= (hit && ren) ? rd_val : '0;
    end
  end

endmodule
